// File: rtl/reli_csr_ctrl_if.sv
// CSR bus interfaces: the single upstream register port and the per-slave
// fan-out bus used by the reliable-TX CSR access controller.

interface reli_csr_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
);
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic              wr_en;
    logic              wr_wait;
    logic              wr_ack;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_wait;
    logic              rd_ack;

    modport master (
        output wr_addr, wr_data, wr_strb, wr_en, rd_addr, rd_en,
        input  wr_wait, wr_ack, rd_data, rd_wait, rd_ack
    );
    modport slave (
        input  wr_addr, wr_data, wr_strb, wr_en, rd_addr, rd_en,
        output wr_wait, wr_ack, rd_data, rd_wait, rd_ack
    );
endinterface

// Fan-out bus: shared address/data, one enable/ack bit per slave and
// per-slave read data packed slave i at [i*DATA_W +: DATA_W].
interface reli_csr_fan_if #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int STRB_W  = DATA_W / 8,
    parameter int NUM_SLV = 3
);
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;
    logic [STRB_W-1:0]         wr_strb;
    logic [NUM_SLV-1:0]        wr_en;
    logic [NUM_SLV-1:0]        wr_ack;
    logic [ADDR_W-1:0]         rd_addr;
    logic [NUM_SLV-1:0]        rd_en;
    logic [NUM_SLV*DATA_W-1:0] rd_data;
    logic [NUM_SLV-1:0]        rd_ack;

    modport master (
        output wr_addr, wr_data, wr_strb, wr_en, rd_addr, rd_en,
        input  wr_ack, rd_data, rd_ack
    );
    modport slave (
        input  wr_addr, wr_data, wr_strb, wr_en, rd_addr, rd_en,
        output wr_ack, rd_data, rd_ack
    );
endinterface

// File: rtl/reli_csr_ctrl.sv
// CSR access controller: page-decodes one upstream CSR port onto three slaves,
// serialises accesses, and serves a local status page with slave-timeout stats.

module reli_csr_ctrl #(
    parameter int                          CSR_ADDR_WIDTH = 16,
    parameter int                          CSR_DATA_WIDTH = 32,
    parameter int                          CSR_STRB_WIDTH = CSR_DATA_WIDTH / 8,
    parameter logic [3:0]                  PSR_PAGE       = 4'h1,
    parameter logic [3:0]                  MAU_PAGE       = 4'h2,
    parameter logic [3:0]                  DEP_PAGE       = 4'h7,
    parameter logic [3:0]                  LOCAL_PAGE     = 4'h0,
    parameter int                          TIMEOUT        = 1024,
    parameter logic [CSR_DATA_WIDTH-1:0]   ERR_DATA       = 32'hBADC0DE0,
    parameter logic [CSR_DATA_WIDTH-1:0]   BLOCK_ID       = 32'h52540001
) (
    input  logic             clk,
    input  logic             rst_n,
    reli_csr_if.slave        s,
    reli_csr_fan_if.master   m,
    output logic             timeout_irq
);

    localparam int NUM_SLV = 3;
    localparam int SEL_W   = 2;
    localparam int OFS_W   = CSR_ADDR_WIDTH - 4;
    localparam int CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [NUM_SLV*4-1:0] SLV_PAGES = {DEP_PAGE, MAU_PAGE, PSR_PAGE};

    typedef enum logic [2:0] {
        IDLE,
        WR_FWD,
        RD_FWD,
        LOCAL,
        RESP
    } state_t;

    state_t                       state_reg;
    logic                         is_wr_reg;
    logic [SEL_W-1:0]             sel_reg;
    logic [CSR_ADDR_WIDTH-1:0]    addr_reg;
    logic [CSR_DATA_WIDTH-1:0]    data_reg;
    logic [CSR_STRB_WIDTH-1:0]    strb_reg;
    logic [CNT_W-1:0]             cnt_reg;
    logic [CSR_DATA_WIDTH-1:0]    timeout_cnt_reg;
    logic [CSR_ADDR_WIDTH-1:0]    last_to_addr_reg;
    logic [CSR_DATA_WIDTH-1:0]    rd_data_reg;
    logic                         wr_ack_reg;
    logic                         rd_ack_reg;
    logic                         irq_reg;

    logic [CSR_ADDR_WIDTH-1:0]    req_addr;
    logic [3:0]                   req_page;
    logic [NUM_SLV-1:0]           req_hit;
    logic [SEL_W-1:0]             req_idx;
    logic [CSR_DATA_WIDTH-1:0]    slv_rd_data [NUM_SLV];
    logic [NUM_SLV-1:0]           sel_onehot;
    logic                         slv_ack;
    logic                         busy;
    logic [CSR_DATA_WIDTH-1:0]    local_rd_data;

    // A simultaneous write and read is resolved in favour of the write.
    assign req_addr = s.wr_en ? s.wr_addr : s.rd_addr;
    assign req_page = req_addr[CSR_ADDR_WIDTH-1 -: 4];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLV; gi++) begin : g_slv
            assign req_hit[gi]     = (req_page == SLV_PAGES[gi*4 +: 4]);
            assign slv_rd_data[gi] = m.rd_data[gi*CSR_DATA_WIDTH +: CSR_DATA_WIDTH];
        end
    endgenerate

    always_comb begin
        req_idx = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (req_hit[i]) begin
                req_idx = SEL_W'(i);
            end
        end
    end

    assign sel_onehot = NUM_SLV'(1) << sel_reg;
    assign slv_ack    = is_wr_reg ? m.wr_ack[sel_reg] : m.rd_ack[sel_reg];

    always_comb begin
        local_rd_data = ERR_DATA;
        if (addr_reg[CSR_ADDR_WIDTH-1 -: 4] == LOCAL_PAGE) begin
            case (addr_reg[OFS_W-1:0])
                OFS_W'(12'h000): local_rd_data = BLOCK_ID;
                OFS_W'(12'h004): local_rd_data = timeout_cnt_reg;
                OFS_W'(12'h008): local_rd_data = CSR_DATA_WIDTH'(last_to_addr_reg);
                default:         local_rd_data = ERR_DATA;
            endcase
        end
    end

    // Slave enables decode straight from the state register so that an
    // asynchronous reset drops them without waiting for a clock edge.
    assign m.wr_en   = (state_reg == WR_FWD) ? sel_onehot : '0;
    assign m.rd_en   = (state_reg == RD_FWD) ? sel_onehot : '0;
    assign m.wr_addr = addr_reg;
    assign m.rd_addr = addr_reg;
    assign m.wr_data = data_reg;
    assign m.wr_strb = strb_reg;

    assign busy      = (state_reg == WR_FWD) || (state_reg == RD_FWD) || (state_reg == LOCAL);
    assign s.wr_wait = busy && (is_wr_reg || s.wr_en);
    assign s.rd_wait = busy && (!is_wr_reg || s.rd_en);
    assign s.wr_ack  = wr_ack_reg;
    assign s.rd_ack  = rd_ack_reg;
    assign s.rd_data = rd_data_reg;
    assign timeout_irq = irq_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            is_wr_reg        <= 1'b0;
            sel_reg          <= '0;
            addr_reg         <= '0;
            data_reg         <= '0;
            strb_reg         <= '0;
            cnt_reg          <= '0;
            timeout_cnt_reg  <= '0;
            last_to_addr_reg <= '0;
            rd_data_reg      <= '0;
            wr_ack_reg       <= 1'b0;
            rd_ack_reg       <= 1'b0;
            irq_reg          <= 1'b0;
        end else begin
            wr_ack_reg <= 1'b0;
            rd_ack_reg <= 1'b0;
            irq_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (s.wr_en || s.rd_en) begin
                        is_wr_reg <= s.wr_en;
                        addr_reg  <= req_addr;
                        sel_reg   <= req_idx;
                        cnt_reg   <= '0;
                        if (s.wr_en) begin
                            data_reg <= s.wr_data;
                            strb_reg <= s.wr_strb;
                        end
                        if (|req_hit) begin
                            state_reg <= s.wr_en ? WR_FWD : RD_FWD;
                        end else begin
                            state_reg <= LOCAL;
                        end
                    end
                end
                WR_FWD, RD_FWD: begin
                    if (slv_ack) begin
                        state_reg <= RESP;
                        if (is_wr_reg) begin
                            wr_ack_reg <= 1'b1;
                        end else begin
                            rd_ack_reg  <= 1'b1;
                            rd_data_reg <= slv_rd_data[sel_reg];
                        end
                    end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        state_reg        <= RESP;
                        irq_reg          <= 1'b1;
                        last_to_addr_reg <= addr_reg;
                        if (timeout_cnt_reg != '1) begin
                            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
                        end
                        if (is_wr_reg) begin
                            wr_ack_reg <= 1'b1;
                        end else begin
                            rd_ack_reg  <= 1'b1;
                            rd_data_reg <= ERR_DATA;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                LOCAL: begin
                    // The local page is read-only: writes are acked and dropped.
                    state_reg <= RESP;
                    if (is_wr_reg) begin
                        wr_ack_reg <= 1'b1;
                    end else begin
                        rd_ack_reg  <= 1'b1;
                        rd_data_reg <= local_rd_data;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reli_csr_ctrl.sv
// Self-checking bench for reli_csr_ctrl: directed scenarios plus randomized
// accesses checked against a page-level behavioural model.

module tb_reli_csr_ctrl;

    localparam int          TIMEOUT  = 1024;
    localparam logic [31:0] ERR_DATA = 32'hBADC0DE0;
    localparam logic [31:0] BLOCK_ID = 32'h52540001;

    logic clk = 1'b0;
    logic rst_n;
    logic timeout_irq;

    int errors = 0;
    int checks = 0;

    int          mdl_tcnt = 0;
    logic [15:0] mdl_last = 16'h0;

    always #5 clk = ~clk;

    reli_csr_if     #(.ADDR_W(16), .DATA_W(32), .STRB_W(4))               s_if ();
    reli_csr_fan_if #(.ADDR_W(16), .DATA_W(32), .STRB_W(4), .NUM_SLV(3)) m_if ();

    reli_csr_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s           (s_if),
        .m           (m_if),
        .timeout_irq (timeout_irq)
    );

    // Slave index owning a page, or -1 for local/unmapped.
    function automatic int mdl_slave(input logic [15:0] a);
        case (a[15:12])
            4'h1:    return 0;
            4'h2:    return 1;
            4'h7:    return 2;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] mdl_local_read(input logic [15:0] a);
        if (a[15:12] != 4'h0) return ERR_DATA;
        case (a[11:0])
            12'h000: return BLOCK_ID;
            12'h004: return 32'(mdl_tcnt);
            12'h008: return {16'h0, mdl_last};
            default: return ERR_DATA;
        endcase
    endfunction

    // Issues one access and plays the slave; ack_dly < 0 means the slave never acks.
    task automatic run_access(
        input  bit          is_wr,
        input  logic [15:0] addr,
        input  logic [31:0] wdata,
        input  logic [3:0]  strb,
        input  int          ack_dly,
        input  logic [31:0] sl_data,
        input  bit          noise,
        input  bit          late_ack,
        output int          ack_cyc,
        output logic [31:0] rdata,
        output logic [2:0]  en_seen,
        output logic [15:0] f_addr,
        output logic [31:0] f_data,
        output logic [3:0]  f_strb,
        output int          irq_cyc,
        output int          hs_bad
    );
        int         cyc;
        int         en_first;
        logic [2:0] en_now;
        ack_cyc = -1; rdata = '0; en_seen = '0; f_addr = '0; f_data = '0; f_strb = '0;
        irq_cyc = -1; hs_bad = 0; en_first = -1; cyc = 0;
        m_if.rd_data = {$urandom, $urandom, $urandom};
        if (is_wr) begin
            s_if.wr_addr = addr; s_if.wr_data = wdata; s_if.wr_strb = strb; s_if.wr_en = 1'b1;
        end else begin
            s_if.rd_addr = addr; s_if.rd_en = 1'b1;
        end
        while (ack_cyc < 0 && cyc < TIMEOUT + 80) begin
            @(posedge clk); #1; cyc++;
            m_if.wr_ack = '0; m_if.rd_ack = '0;
            if (timeout_irq) irq_cyc = cyc;
            if (is_wr ? s_if.wr_ack : s_if.rd_ack) begin
                ack_cyc = cyc;
                rdata   = s_if.rd_data;
                if (is_wr ? s_if.wr_wait : s_if.rd_wait) hs_bad++;
                s_if.wr_en = 1'b0; s_if.rd_en = 1'b0;
                if (late_ack) begin
                    if (is_wr) m_if.wr_ack = en_seen; else m_if.rd_ack = en_seen;
                end
            end else begin
                if (!(is_wr ? s_if.wr_wait : s_if.rd_wait)) hs_bad++;
                en_now  = is_wr ? m_if.wr_en : m_if.rd_en;
                en_seen = en_seen | en_now;
                if (en_now != 0 && en_first < 0) begin
                    en_first = cyc;
                    f_addr = is_wr ? m_if.wr_addr : m_if.rd_addr;
                    f_data = m_if.wr_data;
                    f_strb = m_if.wr_strb;
                end
                if (en_now != 0 && ack_dly >= 0 && cyc - en_first == ack_dly) begin
                    if (is_wr) m_if.wr_ack = en_now;
                    else begin
                        m_if.rd_ack = en_now;
                        for (int i = 0; i < 3; i++)
                            if (en_now[i]) m_if.rd_data[i*32 +: 32] = sl_data;
                    end
                end else if (noise) begin
                    if (is_wr) m_if.wr_ack = ~en_now & 3'($urandom);
                    else       m_if.rd_ack = ~en_now & 3'($urandom);
                end
            end
        end
        s_if.wr_en = 1'b0; s_if.rd_en = 1'b0;
        @(posedge clk); #1;
        m_if.wr_ack = '0; m_if.rd_ack = '0;
        if (s_if.wr_ack || s_if.rd_ack || m_if.wr_en != 0 || m_if.rd_en != 0) hs_bad++;
        if (timeout_irq) irq_cyc = -2;
        $display("txn %s addr=%h ack_cyc=%0d rdata=%h en=%b irq_cyc=%0d",
                 is_wr ? "WR" : "RD", addr, ack_cyc, rdata, en_seen, irq_cyc);
    endtask

    // Local read whose expected value comes from the model.
    task automatic check_local_read(input logic [15:0] addr, input string name);
        int ac, ic, hb; logic [31:0] rd, fd; logic [2:0] en; logic [15:0] fa; logic [3:0] fs;
        logic [31:0] exp_rd;
        exp_rd = mdl_local_read(addr);
        run_access(0, addr, '0, '0, 0, '0, 1, 0, ac, rd, en, fa, fd, fs, ic, hb);
        checks++;
        if (rd !== exp_rd || ac != 2 || en !== 3'b000 || hb != 0)
            $display("FAIL %s: rdata=%h ack_cyc=%0d en=%b hs=%0d, need rdata=%h ack_cyc=2 en=000 hs=0",
                     name, rd, ac, en, hb, exp_rd);
        if (rd !== exp_rd || ac != 2 || en !== 3'b000 || hb != 0) errors++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        s_if.wr_addr = '0; s_if.wr_data = '0; s_if.wr_strb = '0; s_if.wr_en = 1'b0;
        s_if.rd_addr = '0; s_if.rd_en = 1'b0;
        m_if.wr_ack = '0; m_if.rd_ack = '0; m_if.rd_data = '0;
        #23;
        checks++;
        if (m_if.wr_en !== 3'b0 || m_if.rd_en !== 3'b0) begin
            errors++; $display("FAIL reset_en: wr_en=%b rd_en=%b, need 000", m_if.wr_en, m_if.rd_en);
        end
        checks++;
        if ({s_if.wr_ack, s_if.rd_ack, s_if.wr_wait, s_if.rd_wait, timeout_irq} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: ack/wait/irq=%b, need 00000",
                     {s_if.wr_ack, s_if.rd_ack, s_if.wr_wait, s_if.rd_wait, timeout_irq});
        end
        checks++;
        if (s_if.rd_data !== 32'h0) begin
            errors++; $display("FAIL reset_rd_data: got %h, need 00000000", s_if.rd_data);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_local_read(16'h0004, "reset_timeout_cnt");
        check_local_read(16'h0008, "reset_last_to_addr");
    endtask

    task automatic test_fwd_write;
        int ac, ic, hb; logic [31:0] rd, fd; logic [2:0] en; logic [15:0] fa; logic [3:0] fs;
        run_access(1, 16'h2010, 32'hA5A5A5A5, 4'hF, 3, '0, 0, 0, ac, rd, en, fa, fd, fs, ic, hb);
        checks++;
        if (ac != 5 || en !== 3'b010) begin
            errors++; $display("FAIL fwd_write_ack: ack_cyc=%0d en=%b, need 5 010", ac, en);
        end
        checks++;
        if (fd !== 32'hA5A5A5A5 || fa !== 16'h2010 || fs !== 4'hF) begin
            errors++; $display("FAIL fwd_write_bus: addr=%h data=%h strb=%h, need 2010 a5a5a5a5 f", fa, fd, fs);
        end
        checks++;
        if (hb != 0 || ic != -1) begin
            errors++; $display("FAIL fwd_write_hs: hs=%0d irq_cyc=%0d, need 0 -1", hb, ic);
        end
    endtask

    task automatic test_fwd_read;
        int ac, ic, hb; logic [31:0] rd, fd; logic [2:0] en; logic [15:0] fa; logic [3:0] fs;
        run_access(0, 16'h7004, '0, '0, 2, 32'h12345678, 0, 0, ac, rd, en, fa, fd, fs, ic, hb);
        checks++;
        if (rd !== 32'h12345678 || ac != 4) begin
            errors++; $display("FAIL fwd_read_data: rdata=%h ack_cyc=%0d, need 12345678 4", rd, ac);
        end
        checks++;
        if (en !== 3'b100 || fa !== 16'h7004 || hb != 0) begin
            errors++; $display("FAIL fwd_read_bus: en=%b addr=%h hs=%0d, need 100 7004 0", en, fa, hb);
        end
    endtask

    task automatic test_simultaneous;
        logic [5:0] obs;
        s_if.wr_addr = 16'h1000; s_if.wr_data = 32'h0BADF00D; s_if.wr_strb = 4'h3; s_if.wr_en = 1'b1;
        s_if.rd_addr = 16'h0000; s_if.rd_en = 1'b1;
        @(posedge clk); #1;
        checks++;
        obs = {m_if.wr_en, m_if.rd_en};
        if (obs !== 6'b001_000 || s_if.rd_wait !== 1'b1 || s_if.wr_wait !== 1'b1) begin
            errors++;
            $display("FAIL simul_write_first: wr_en/rd_en=%b rd_wait=%b wr_wait=%b, need 001000 1 1",
                     obs, s_if.rd_wait, s_if.wr_wait);
        end
        m_if.wr_ack = 3'b001;
        @(posedge clk); #1;
        m_if.wr_ack = '0;
        checks++;
        if ({s_if.wr_ack, s_if.rd_ack, s_if.rd_wait} !== 3'b100) begin
            errors++; $display("FAIL simul_write_ack: wr_ack/rd_ack/rd_wait=%b, need 100",
                               {s_if.wr_ack, s_if.rd_ack, s_if.rd_wait});
        end
        s_if.wr_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (s_if.rd_ack !== 1'b0 || s_if.rd_wait !== 1'b1) begin
            errors++; $display("FAIL simul_read_pending: rd_ack=%b rd_wait=%b, need 0 1", s_if.rd_ack, s_if.rd_wait);
        end
        @(posedge clk); #1;
        checks++;
        if (s_if.rd_ack !== 1'b1 || s_if.rd_data !== BLOCK_ID) begin
            errors++; $display("FAIL simul_read_ack: rd_ack=%b rdata=%h, need 1 %h", s_if.rd_ack, s_if.rd_data, BLOCK_ID);
        end
        s_if.rd_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_timeout;
        int ac, ic, hb; logic [31:0] rd, fd; logic [2:0] en; logic [15:0] fa; logic [3:0] fs;
        run_access(0, 16'h2000, '0, '0, -1, '0, 1, 1, ac, rd, en, fa, fd, fs, ic, hb);
        mdl_tcnt++; mdl_last = 16'h2000;
        checks++;
        if (ac != TIMEOUT + 1 || rd !== ERR_DATA || en !== 3'b010) begin
            errors++; $display("FAIL timeout_read: ack_cyc=%0d rdata=%h en=%b, need %0d %h 010",
                               ac, rd, en, TIMEOUT + 1, ERR_DATA);
        end
        checks++;
        if (ic != TIMEOUT + 1 || hb != 0) begin
            errors++; $display("FAIL timeout_irq: irq_cyc=%0d hs=%0d, need %0d 0", ic, hb, TIMEOUT + 1);
        end
        check_local_read(16'h0004, "timeout_cnt_1");
        check_local_read(16'h0008, "last_to_addr_1");
        run_access(1, 16'h7000, 32'hCAFEBABE, 4'h1, -1, '0, 0, 0, ac, rd, en, fa, fd, fs, ic, hb);
        mdl_tcnt++; mdl_last = 16'h7000;
        checks++;
        if (ac != TIMEOUT + 1 || ic != TIMEOUT + 1 || en !== 3'b100 || hb != 0) begin
            errors++; $display("FAIL timeout_write: ack_cyc=%0d irq_cyc=%0d en=%b hs=%0d, need %0d %0d 100 0",
                               ac, ic, en, hb, TIMEOUT + 1, TIMEOUT + 1);
        end
        check_local_read(16'h0004, "timeout_cnt_2");
        check_local_read(16'h0008, "last_to_addr_2");
    endtask

    task automatic test_local_unmapped;
        int ac, ic, hb; logic [31:0] rd, fd; logic [2:0] en; logic [15:0] fa; logic [3:0] fs;
        check_local_read(16'h5000, "unmapped_read");
        check_local_read(16'h0FF0, "local_bad_offset");
        run_access(1, 16'h0004, 32'h00000077, 4'hF, 0, '0, 0, 0, ac, rd, en, fa, fd, fs, ic, hb);
        checks++;
        if (ac != 2 || en !== 3'b000 || hb != 0) begin
            errors++; $display("FAIL local_write_ack: ack_cyc=%0d en=%b hs=%0d, need 2 000 0", ac, en, hb);
        end
        check_local_read(16'h0004, "local_write_discard");
        check_local_read(16'h0000, "block_id");
    endtask

    task automatic test_random;
        logic [3:0]  pages [6] = '{4'h0, 4'h1, 4'h2, 4'h7, 4'h3, 4'hF};
        logic [11:0] ofs   [4] = '{12'h000, 12'h004, 12'h008, 12'h0C0};
        int ac, ic, hb, idx, dly, exp_ac; logic [31:0] rd, fd, wd, sd, exp_rd;
        logic [2:0] en, exp_en; logic [15:0] fa, addr; logic [3:0] fs, st; bit wr;
        for (int n = 0; n < 40; n++) begin
            wr   = 1'($urandom);
            addr = {pages[$urandom_range(0, 5)], ofs[$urandom_range(0, 3)]};
            wd   = $urandom; sd = $urandom; st = 4'($urandom);
            dly  = $urandom_range(0, 15);
            idx  = mdl_slave(addr);
            exp_rd = (idx >= 0) ? sd : mdl_local_read(addr);
            exp_en = (idx >= 0) ? 3'(1 << idx) : 3'b000;
            exp_ac = (idx >= 0) ? dly + 2 : 2;
            run_access(wr, addr, wd, st, dly, sd, 1, 0, ac, rd, en, fa, fd, fs, ic, hb);
            checks++;
            if (ac != exp_ac || en !== exp_en || hb != 0 || ic != -1) begin
                errors++; $display("FAIL rand_hs[%0d]: ack_cyc=%0d en=%b hs=%0d irq=%0d, need %0d %b 0 -1",
                                   n, ac, en, hb, ic, exp_ac, exp_en);
            end
            if (!wr) begin
                checks++;
                if (rd !== exp_rd) begin
                    errors++; $display("FAIL rand_rdata[%0d]: got %h, need %h", n, rd, exp_rd);
                end
            end else if (idx >= 0) begin
                checks++;
                if (fd !== wd || fs !== st || fa !== addr) begin
                    errors++; $display("FAIL rand_wbus[%0d]: addr=%h data=%h strb=%h, need %h %h %h",
                                       n, fa, fd, fs, addr, wd, st);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int ac, ic, hb; logic [31:0] rd, fd; logic [2:0] en; logic [15:0] fa; logic [3:0] fs;
        s_if.wr_addr = 16'h2010; s_if.wr_data = 32'h11112222; s_if.wr_strb = 4'hF; s_if.wr_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (m_if.wr_en !== 3'b010) begin
            errors++; $display("FAIL rstmid_before: wr_en=%b, need 010", m_if.wr_en);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (m_if.wr_en !== 3'b000 || s_if.wr_ack !== 1'b0 || s_if.wr_wait !== 1'b0) begin
            errors++; $display("FAIL rstmid_drop: wr_en=%b wr_ack=%b wr_wait=%b, need 000 0 0",
                               m_if.wr_en, s_if.wr_ack, s_if.wr_wait);
        end
        s_if.wr_en = 1'b0;
        mdl_tcnt = 0; mdl_last = 16'h0;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (s_if.wr_ack !== 1'b0 || m_if.wr_en !== 3'b000) begin
            errors++; $display("FAIL rstmid_noack: wr_ack=%b wr_en=%b, need 0 000", s_if.wr_ack, m_if.wr_en);
        end
        check_local_read(16'h0004, "rstmid_timeout_cnt");
        check_local_read(16'h0008, "rstmid_last_to_addr");
        run_access(1, 16'h1004, 32'h600DD00D, 4'h5, 1, '0, 0, 0, ac, rd, en, fa, fd, fs, ic, hb);
        checks++;
        if (ac != 3 || en !== 3'b001 || fd !== 32'h600DD00D || hb != 0) begin
            errors++; $display("FAIL rstmid_after: ack_cyc=%0d en=%b data=%h hs=%0d, need 3 001 600dd00d 0",
                               ac, en, fd, hb);
        end
    endtask

    initial begin
        test_reset();
        test_fwd_write();
        test_fwd_read();
        test_simultaneous();
        test_timeout();
        test_local_unmapped();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reli_csr_ctrl.md
Name: reli_csr_ctrl

Overview:
- CSR access controller for the reliable-TX pipeline.
- Decodes the single upstream CSR register interface (write and read channels) by address page (addr[15:12]) and forwards each access to exactly one of three slaves: parser, MAU, deparser.
- Serialises write and read accesses, merges wait/ack/data back to the master, and owns a local status page holding a timeout counter for slaves that never acknowledge.

Parameters:
CSR_ADDR_WIDTH, 16, CSR address width (page = addr[15:12])
CSR_DATA_WIDTH, 32, CSR data width
CSR_STRB_WIDTH, CSR_DATA_WIDTH/8, byte-strobe width
PSR_PAGE, 4'h1, page routed to slave 0 (parser)
MAU_PAGE, 4'h2, page routed to slave 1 (MAU)
DEP_PAGE, 4'h7, page routed to slave 2 (deparser)
LOCAL_PAGE, 4'h0, page served internally
TIMEOUT, 1024, max cycles a slave may take to ack
ERR_DATA, 32'hBADC0DE0, read data returned on timeout or unmapped read
BLOCK_ID, 32'h52540001, value of local ID register

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_wr_addr  in  CSR_ADDR_WIDTH  master write address
s_wr_data  in  CSR_DATA_WIDTH  master write data
s_wr_strb  in  CSR_STRB_WIDTH  master write strobes
s_wr_en  in  1  write request, held until s_wr_ack
s_wr_wait  out  1  write accepted and pending
s_wr_ack  out  1  write done, 1-cycle pulse
s_rd_addr  in  CSR_ADDR_WIDTH  master read address
s_rd_en  in  1  read request, held until s_rd_ack
s_rd_data  out  CSR_DATA_WIDTH  read data, valid with s_rd_ack
s_rd_wait  out  1  read accepted and pending
s_rd_ack  out  1  read done, 1-cycle pulse
m_wr_addr  out  CSR_ADDR_WIDTH  forwarded write address (shared by all slaves)
m_wr_data  out  CSR_DATA_WIDTH  forwarded write data
m_wr_strb  out  CSR_STRB_WIDTH  forwarded write strobes
m_wr_en  out  3  per-slave write enable, bit i = slave i
m_wr_ack  in  3  per-slave write ack
m_rd_addr  out  CSR_ADDR_WIDTH  forwarded read address
m_rd_en  out  3  per-slave read enable
m_rd_data  in  3*CSR_DATA_WIDTH  per-slave read data, slave i at bits [i*32 +: 32]
m_rd_ack  in  3  per-slave read ack
timeout_irq  out  1  1-cycle pulse on each timeout

Behaviour:
- FSM states: IDLE, WR_FWD, RD_FWD, LOCAL, RESP.
- IDLE: when s_wr_en=1, latch write address/data/strb. If both s_wr_en and s_rd_en are 1, the write wins and the read stays pending with s_rd_wait=1.
  - Page equals a slave page: go to WR_FWD.
  - Otherwise: go to LOCAL.
- IDLE, read only: same decode, going to RD_FWD or LOCAL.
- WR_FWD / RD_FWD:
  - m_*_en bit of the selected slave = 1, combinational from the state register; all other bits = 0.
  - m_*_addr/data/strb driven from the latched copies, stable for the whole access.
  - On the selected slave's ack: go to RESP. The master ack is registered, so s_*_ack = 1 the cycle after the slave ack, and s_rd_data = the captured slave data.
  - Acks from non-selected slaves are ignored.
- Timeout:
  - A cycle counter clears on entering a FWD state.
  - If it reaches TIMEOUT-1 with no ack: go to RESP, s_rd_data = ERR_DATA, timeout_cnt increments (saturating at all-ones), last_to_addr takes the latched address, timeout_irq pulses.
  - Writes acknowledge normally on timeout.
  - A slave ack arriving after leaving FWD is ignored.
- LOCAL: exactly one cycle, then RESP. Local write page is read-only; writes are acked and discarded.
  - Local read map, offset addr[11:0]: 0x000 = BLOCK_ID, 0x004 = timeout_cnt, 0x008 = last_to_addr zero-extended.
  - Any other local offset, or an unmapped page, reads ERR_DATA.
- RESP:
  - s_wr_ack or s_rd_ack = 1 for this one cycle.
  - s_*_wait = 0 in RESP.
  - s_*_wait = 1 in FWD/LOCAL for the channel being served, and for a pending request of the other channel.
  - Next state is always IDLE. The requests are not sampled in RESP, so the master has one cycle to drop en.
- Latency, request seen in IDLE at cycle 0:
  - local/unmapped: ack at cycle 2
  - forwarded: ack at cycle (slave ack cycle + 1)
  - timeout: ack at cycle TIMEOUT+1
- Reset (async, rst_n=0):
  - state = IDLE
  - all m_*_en = 0, s_*_ack = 0, s_*_wait = 0, timeout_irq = 0
  - s_rd_data = 0, timeout_cnt = 0, last_to_addr = 0
- Reset asserted mid-access: the access is dropped with no ack, and slave enables fall immediately.
- Only one access is outstanding at a time.

Test Plan:
1. Write addr 0x2010, data 0xA5A5A5A5, strb 0xF; MAU acks 3 cycles after m_wr_en[1] rises -> only m_wr_en[1] high, m_wr_data=0xA5A5A5A5, s_wr_ack 1 cycle after slave ack.
2. Read 0x7004, deparser returns 0x12345678 on ack -> s_rd_ack with s_rd_data=0x12345678, m_rd_en[2] only.
3. Simultaneous write 0x1000 and read 0x0000 -> write completes first (s_rd_wait=1 meanwhile); read then returns 0x52540001 at 2 cycles after its IDLE sample.
4. Read 0x2000, MAU never acks -> s_rd_ack at cycle 1025 with data 0xBADC0DE0, timeout_irq pulse; read 0x0004 -> 1, read 0x0008 -> 0x2000; late MAU ack ignored.
5. Read unmapped 0x5000 and local offset 0x0FF0 -> both return 0xBADC0DE0 with ack at cycle 2; timeout_cnt unchanged.
6. Assert rst_n=0 during WR_FWD -> m_wr_en drops in the same cycle, no s_wr_ack; after release, a new access completes normally and timeout_cnt=0.
